// File: rtl/q_meter.sv
// Plant-side measurement responder: drives the requested current onto the DAC, waits for the
// settle time, then averages 2^AVG_LOG2 ADC Q samples and pulses ready with the result.
module q_meter #(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_ref,
  input  logic             i_ref_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] measured_q,
  output logic             ready,
  output logic             busy
);

  localparam int unsigned AccW = WIDTH + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0] LastCnt    = CntW'((1 << AVG_LOG2) - 1);
  localparam logic [15:0]     SettleInit = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StAccum} state_e;

  state_e           state_q;
  logic [15:0]      settle_q;
  logic [AccW-1:0]  acc_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] dac_q;
  logic [WIDTH-1:0] meas_q;
  logic             ready_q;
  logic             busy_q;

  logic [AccW-1:0] acc_sum;
  assign acc_sum = acc_q + AccW'(sample);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      settle_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dac_q    <= '0;
      meas_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      // A new request wins in every state, including over a completing sample.
      if (i_ref_valid) begin
        dac_q    <= i_ref;
        settle_q <= SettleInit;
        acc_q    <= '0;
        cnt_q    <= '0;
        state_q  <= StSettle;
        busy_q   <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            busy_q <= 1'b0;
          end
          StSettle: begin
            if (settle_q == '0) begin
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= StAccum;
            end else begin
              settle_q <= settle_q - 16'd1;
            end
          end
          StAccum: begin
            if (sample_valid) begin
              if (cnt_q == LastCnt) begin
                meas_q  <= WIDTH'(acc_sum >> AVG_LOG2);
                ready_q <= 1'b1;
                acc_q   <= '0;
                cnt_q   <= '0;
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                acc_q <= acc_sum;
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dac_code   = dac_q;
  assign measured_q = meas_q;
  assign ready      = ready_q;
  assign busy       = busy_q;

endmodule

// File: doc/q_meter.md
Name: q_meter

Overview:
- Measurement responder at the plant end of the control loop.
- Accepts a current-reference request (i_ref plus strobe) from the bisection/secant controller and drives it onto the current-DAC code.
- After a programmable settle time, averages a power-of-two number of ADC Q samples.
- Returns measured_q with a one-cycle ready pulse, which the controller consumes as its handshake.

Parameters:
- WIDTH, 10: width of i_ref, dac_code, sample and measured_q.
- SETTLE_CYCLES, 16: cycles to wait after a new dac_code before sampling; legal range 1..2^16-1.
- AVG_LOG2, 2: log2 of the number of averaged samples (N = 2^AVG_LOG2); legal range 0..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_ref  input  WIDTH  requested current reference code from the controller.
- i_ref_valid  input  1  request strobe; i_ref is sampled on a clk edge where this is 1.
- sample  input  WIDTH  Q sample from the ADC front end.
- sample_valid  input  1  sample qualifier; sample is accepted only when this is 1 in ACCUM.
- dac_code  output  WIDTH  registered current-DAC code, equal to the last accepted i_ref.
- measured_q  output  WIDTH  registered averaged Q of the last completed measurement.
- ready  output  1  one-cycle pulse marking a new measured_q.
- busy  output  1  1 whenever the state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; dac_code=0, measured_q=0, ready=0, busy=0.
  - Accumulator, sample counter and settle counter all cleared.
  - Any in-flight measurement is discarded and produces no ready pulse.
- States: IDLE, SETTLE, ACCUM.
- IDLE:
  - i_ref_valid=1: dac_code<=i_ref, settle counter<=SETTLE_CYCLES-1, state->SETTLE.
  - sample_valid is ignored.
- SETTLE:
  - When the counter is 0: state->ACCUM, accumulator<=0, sample count<=0.
  - Otherwise the counter decrements by 1.
  - sample_valid is ignored.
- ACCUM:
  - sample_valid=1: accumulator += sample (zero-extended), count += 1.
  - On the edge that accepts sample N: measured_q<=(accumulator+sample)>>AVG_LOG2 (truncating), ready<=1, state->IDLE.
  - sample_valid=0 holds the state and extends latency; there is no timeout.
- Width rules:
  - Accumulator is WIDTH+AVG_LOG2 bits unsigned, so it never overflows.
  - Average is floor(sum/N).
- ready:
  - Registered; high for exactly the one cycle after the completing edge.
  - measured_q first shows the new value in that same cycle and holds until the next completion or reset.
- Latency:
  - Request accepted at edge E0, sample_valid held at 1: samples are accepted at edges E0+S+1 .. E0+S+N, and ready is high after edge E0+S+N (S=SETTLE_CYCLES).
  - Defaults: 20 cycles.
- Restart:
  - i_ref_valid=1 in SETTLE or ACCUM: new i_ref is latched into dac_code, the settle counter is reloaded, the partial accumulation is discarded, and state->SETTLE.
  - The aborted measurement produces no ready.
  - Restart beats completion: i_ref_valid on the same edge as the final sample suppresses ready and leaves measured_q unchanged.
- Back-to-back: i_ref_valid in the cycle where ready=1 (state IDLE) is accepted normally; ready still deasserts next cycle.
- busy is a registered decode of state; it is 1 from the edge after acceptance until the completing edge.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then release with no requests -> dac_code=0, measured_q=0, ready=0, busy=0 for 50 cycles.
- Basic measurement:
  - Stimulus: i_ref=512 strobed, sample=100 constant, sample_valid=1, defaults.
  - Required: dac_code=512 one cycle after the strobe; busy=1; ready pulses exactly once, 20 cycles after the accepting edge; measured_q=100.
- Averaging/truncation: samples 10, 11, 12, 13 in ACCUM -> measured_q=11. Samples 1023 ×4 -> measured_q=1023 (no overflow).
- Stalled sampling: sample_valid low for 5 cycles mid-ACCUM -> ready delayed by exactly 5 cycles and the average is unchanged.
- Restart:
  - Stimulus: i_ref=300 at E0, then i_ref=700 strobed during ACCUM after 2 samples.
  - Required: dac_code=700; no ready for the 300 request; ready 20 cycles after the second strobe.
  - Also: a strobe coincident with the final sample gives no ready and measured_q unchanged.
- Reset mid-operation: rst=0 asserted asynchronously during SETTLE -> outputs clear immediately, with no ready before or after release.
